// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with load-A/load-B operand registers, a
// registered double-width result and a multi-cycle shift-add multiplier.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   operand_a, operand_b     values captured into reg_a / reg_b on load_a / load_b
//   alu_op, start            operation select and launch (start ignored while busy)
//   busy                     multiply in progress
//   done                     one-cycle pulse, result/flags just updated
//   result                   registered 2*WIDTH result
//   zero/carry/overflow/negative_flag   registered flags, hold between updates
//
// state     | meaning
// ST_IDLE   | accepts start; single-cycle ops complete at the start edge
// ST_MULT   | shift-add multiply, one multiplier bit per clock
module alu_seq_core #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   input  logic                 load_a,
   input  logic                 load_b,
   input  logic [3:0]           alu_op,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 zero_flag,
   output logic                 carry_flag,
   output logic                 overflow_flag,
   output logic                 negative_flag
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MULT = 1'b1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_ASR = 4'd9;

   logic [0:0]           state;
   logic [WIDTH-1:0]     reg_a, reg_b;
   logic [WIDTH-1:0]     work_a, work_b;
   logic [2*WIDTH-1:0]   acc;
   logic [SHW-1:0]       cnt;

   logic [SHW-1:0]       amt;
   logic [WIDTH:0]       sum_add, sum_sub, shl_x, shr_x;
   logic signed [WIDTH:0] asr_x;
   logic [WIDTH-1:0]     op_res;
   logic                 op_c, op_v, op_z, op_n, op_upd;
   logic [2*WIDTH-1:0]   mul_term, acc_next;

   assign amt     = reg_b[SHW-1:0];
   assign sum_add = {1'b0, reg_a} + {1'b0, reg_b};
   assign sum_sub = {1'b0, reg_a} + {1'b0, ~reg_b} + {{WIDTH{1'b0}}, 1'b1};
   // One guard bit on the shifted-out side captures the last bit lost.
   assign shl_x   = {1'b0, reg_a} << amt;
   assign shr_x   = {reg_a, 1'b0} >> amt;
   assign asr_x   = $signed({reg_a, 1'b0}) >>> amt;

   always_comb begin
      op_res = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      op_upd = 1'b1;
      case (alu_op)
         OP_ADD: begin
            op_res = sum_add[WIDTH-1:0];
            op_c   = sum_add[WIDTH];
            op_v   = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) && (sum_add[WIDTH-1] != reg_a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            op_res = sum_sub[WIDTH-1:0];
            op_c   = sum_sub[WIDTH];
            op_v   = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (sum_sub[WIDTH-1] != reg_a[WIDTH-1]);
            // CMP only updates the flags; the result register keeps its value.
            op_upd = (alu_op == OP_SUB);
         end
         OP_AND: op_res = reg_a & reg_b;
         OP_OR:  op_res = reg_a | reg_b;
         OP_XOR: op_res = reg_a ^ reg_b;
         OP_SHL: begin
            op_res = shl_x[WIDTH-1:0];
            op_c   = shl_x[WIDTH];
         end
         OP_SHR: begin
            op_res = shr_x[WIDTH:1];
            op_c   = shr_x[0];
         end
         OP_ASR: begin
            op_res = asr_x[WIDTH:1];
            op_c   = asr_x[0];
         end
         default: op_res = '0;
      endcase
   end

   assign op_z = (op_res == '0);
   assign op_n = op_res[WIDTH-1];

   assign mul_term = work_b[cnt] ? ({{WIDTH{1'b0}}, work_a} << cnt) : '0;
   assign acc_next = acc + mul_term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         reg_a         <= '0;
         reg_b         <= '0;
         work_a        <= '0;
         work_b        <= '0;
         acc           <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         result        <= '0;
         zero_flag     <= 1'b0;
         carry_flag    <= 1'b0;
         overflow_flag <= 1'b0;
         negative_flag <= 1'b0;
      end else begin
         if (load_a) reg_a <= operand_a;
         if (load_b) reg_b <= operand_b;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  work_a <= reg_a;
                  work_b <= reg_b;
                  if (alu_op == OP_MUL) begin
                     state <= ST_MULT;
                     busy  <= 1'b1;
                     acc   <= '0;
                     cnt   <= '0;
                  end else begin
                     done <= 1'b1;
                     if (op_upd) result <= {{WIDTH{1'b0}}, op_res};
                     zero_flag     <= op_z;
                     carry_flag    <= op_c;
                     overflow_flag <= op_v;
                     negative_flag <= op_n;
                  end
               end
            end
            ST_MULT: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == SHW'(WIDTH-1)) begin
                  state         <= ST_IDLE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  result        <= acc_next;
                  zero_flag     <= (acc_next == '0);
                  carry_flag    <= |acc_next[2*WIDTH-1:WIDTH];
                  overflow_flag <= 1'b0;
                  negative_flag <= acc_next[2*WIDTH-1];
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed bench for alu_seq_core (WIDTH=8) with a
// behavioural reference model compared every cycle, plus literal expectations.
module tb_alu_seq_core;
   localparam int W    = 8;
   localparam int FULL = 256;
   localparam int HALF = 128;

   logic            clk;
   logic            rst;
   logic [W-1:0]    operand_a, operand_b;
   logic            load_a, load_b;
   logic [3:0]      alu_op;
   logic            start;
   logic            busy, done;
   logic [2*W-1:0]  result;
   logic            zero_flag, carry_flag, overflow_flag, negative_flag;

   int checks = 0;
   int errors = 0;

   alu_seq_core #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .operand_a(operand_a), .operand_b(operand_b),
      .load_a(load_a), .load_b(load_b),
      .alu_op(alu_op), .start(start),
      .busy(busy), .done(done), .result(result),
      .zero_flag(zero_flag), .carry_flag(carry_flag),
      .overflow_flag(overflow_flag), .negative_flag(negative_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference arithmetic on plain integers.
   function automatic void model_alu(input int op, input int a, input int b,
                                     output int r, output bit z, output bit c,
                                     output bit v, output bit n, output bit upd);
      int s, sa, sb, sh;
      sa = (a >= HALF) ? a - FULL : a;
      sb = (b >= HALF) ? b - FULL : b;
      sh = b % W;
      r = 0; c = 0; v = 0; upd = 1;
      case (op)
         0: begin
            s = a + b; r = s % FULL; c = (s >= FULL);
            v = (sa + sb > HALF - 1) || (sa + sb < -HALF);
         end
         1, 7: begin
            s = a + (FULL - 1 - b) + 1; r = s % FULL; c = (s >= FULL);
            v = (sa - sb > HALF - 1) || (sa - sb < -HALF);
            upd = (op == 1);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = (a << sh) % FULL; c = (sh != 0) && (((a >> (W - sh)) % 2) == 1); end
         6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) % 2) == 1); end
         9: begin r = (sa >>> sh) & (FULL - 1); c = (sh != 0) && (((a >> (sh - 1)) % 2) == 1); end
         default: r = 0;
      endcase
      z = (r == 0);
      n = (r >= HALF);
   endfunction

   int             m_a, m_b, m_rem;
   logic [2*W-1:0] m_res, p_res;
   logic           m_busy, m_done, m_z, m_c, m_v, m_n;

   always @(posedge clk or posedge rst) begin : model
      int r, p;
      bit z, c, v, n, upd;
      if (rst) begin
         m_a <= 0; m_b <= 0; m_rem <= 0; m_res <= '0; p_res <= '0;
         m_busy <= 1'b0; m_done <= 1'b0;
         m_z <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_n <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_res  <= p_res;
               m_z    <= (p_res == '0);
               m_c    <= (p_res[2*W-1:W] != '0);
               m_v    <= 1'b0;
               m_n    <= p_res[2*W-1];
            end
         end else if (start) begin
            if (alu_op == 4'd8) begin
               p = m_a * m_b;
               p_res  <= p[2*W-1:0];
               m_busy <= 1'b1;
               m_rem  <= W;
            end else begin
               model_alu(int'(alu_op), m_a, m_b, r, z, c, v, n, upd);
               m_done <= 1'b1;
               if (upd) m_res <= (2*W)'(r);
               m_z <= z; m_c <= c; m_v <= v; m_n <= n;
            end
         end
         if (load_a) m_a <= int'(operand_a);
         if (load_b) m_b <= int'(operand_b);
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if ({busy, done, result, zero_flag, carry_flag, overflow_flag, negative_flag} !==
             {m_busy, m_done, m_res, m_z, m_c, m_v, m_n}) begin
            errors++;
            $display("FAIL model_cycle t=%0t got busy=%b done=%b res=%h zcvn=%b%b%b%b exp busy=%b done=%b res=%h zcvn=%b%b%b%b",
                     $time, busy, done, result, zero_flag, carry_flag, overflow_flag, negative_flag,
                     m_busy, m_done, m_res, m_z, m_c, m_v, m_n);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [3:0] zcvn();
      return {zero_flag, carry_flag, overflow_flag, negative_flag};
   endfunction

   // Entered at a negedge; returns at the negedge after the start edge.
   task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      operand_a = a; operand_b = b; load_a = 1'b1; load_b = 1'b1;
      @(negedge clk);
      load_a = 1'b0; load_b = 1'b0; alu_op = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, busy_cnt, done_at;
      rst = 1'b1;
      operand_a = '0; operand_b = '0; load_a = 1'b0; load_b = 1'b0;
      alu_op = '0; start = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_result", 32'(result), 32'h0);
      chk("reset_ctl", {30'd0, busy, done}, 32'h0);
      chk("reset_flags", 32'(zcvn()), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      do_op(4'd0, 8'h7F, 8'h01);
      chk("add_result", 32'(result), 32'h0080);
      chk("add_zcvn", 32'(zcvn()), 32'b0011);
      chk("add_done", 32'(done), 32'h1);
      @(negedge clk);
      chk("add_done_pulse", 32'(done), 32'h0);

      do_op(4'd1, 8'h05, 8'h05);
      chk("sub_result", 32'(result), 32'h0000);
      chk("sub_zcvn", 32'(zcvn()), 32'b1100);
      do_op(4'd7, 8'h03, 8'h04);
      chk("cmp_result", 32'(result), 32'h0000);
      chk("cmp_zcvn", 32'(zcvn()), 32'b0001);

      operand_a = 8'hFF; operand_b = 8'hFF; load_a = 1'b1; load_b = 1'b1;
      @(negedge clk);
      load_a = 1'b0; load_b = 1'b0; alu_op = 4'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; busy_cnt = 0; done_at = 0;
      while (cyc < 20 && done_at == 0) begin
         cyc++;
         if (busy) busy_cnt++;
         if (done) done_at = cyc;
         start     = (cyc == 2);
         load_a    = (cyc == 2);
         alu_op    = (cyc == 2) ? 4'd0 : 4'd8;
         operand_a = (cyc == 2) ? 8'h00 : operand_a;
         if (done_at == 0) @(negedge clk);
      end
      start = 1'b0; load_a = 1'b0;
      chk("mul_busy_cycles", 32'(busy_cnt), 32'd8);
      chk("mul_done_latency", 32'(done_at), 32'd9);
      chk("mul_result", 32'(result), 32'hFE01);
      chk("mul_zcvn", 32'(zcvn()), 32'b0101);
      @(negedge clk);

      do_op(4'd5, 8'h81, 8'h01);
      chk("shl_result", 32'(result), 32'h0002);
      chk("shl_carry", 32'(carry_flag), 32'h1);
      do_op(4'd6, 8'h80, 8'h00);
      chk("shr0_result", 32'(result), 32'h0080);
      chk("shr0_carry", 32'(carry_flag), 32'h0);
      do_op(4'd9, 8'h80, 8'h03);
      chk("asr_result", 32'(result), 32'h00F0);
      chk("asr_carry", 32'(carry_flag), 32'h0);

      do_op(4'd12, 8'h5A, 8'hA5);
      chk("rsv_result", 32'(result), 32'h0000);
      chk("rsv_zcvn", 32'(zcvn()), 32'b1000);

      // Back-to-back ops with start held high, op changing each cycle.
      operand_a = 8'h0C; operand_b = 8'h0A; load_a = 1'b1; load_b = 1'b1;
      @(negedge clk);
      load_a = 1'b0; load_b = 1'b0; alu_op = 4'd0; start = 1'b1;
      @(negedge clk);
      chk("b2b_add", {15'd0, done, result}, {15'd0, 1'b1, 16'h0016});
      alu_op = 4'd4;
      @(negedge clk);
      chk("b2b_xor", {15'd0, done, result}, {15'd0, 1'b1, 16'h0006});
      alu_op = 4'd2;
      @(negedge clk);
      chk("b2b_and", {15'd0, done, result}, {15'd0, 1'b1, 16'h0008});
      start = 1'b0;
      @(negedge clk);
      chk("b2b_idle", 32'(done), 32'h0);

      // Reset three cycles into a multiply.
      operand_a = 8'hFF; operand_b = 8'hFF; load_a = 1'b1; load_b = 1'b1;
      @(negedge clk);
      load_a = 1'b0; load_b = 1'b0; alu_op = 4'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_ctl", {30'd0, busy, done}, 32'h0);
      chk("rst_flags", 32'(zcvn()), 32'h0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      do_op(4'd0, 8'h01, 8'h01);
      chk("post_rst_add", {15'd0, done, result}, {15'd0, 1'b1, 16'h0002});
      @(negedge clk);
      chk("post_rst_done_pulse", 32'(done), 32'h0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
